// File: rtl/alu_arbiter_if.sv
// Request/response bus between two requesters and alu_arbiter.
// Lane i of each packed field belongs to requester i.
interface alu_arbiter_if;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [7:0]  req_op;
    logic [63:0] req_dat1;
    logic [63:0] req_dat2;
    logic [1:0]  req_set;
    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_id;
    logic [31:0] rsp_result;
    logic        rsp_err;

    // Arbiter side
    modport slave (
        input  req_valid, req_op, req_dat1, req_dat2, req_set, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_result, rsp_err
    );

    // Requester / response consumer side
    modport master (
        output req_valid, req_op, req_dat1, req_dat2, req_set, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_result, rsp_err
    );
endinterface

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin arbiter sharing one combinational ALU between
// two requesters. Each accepted request is driven to the ALU for one cycle,
// its result is captured and held as a response until consumed.
// Optional feature macro: ALU_ARB_OPCHECK_EN -- opcodes above 5 are accepted
// but answered with result 0 and rsp_err=1, leaving the flags untouched.
module alu_arbiter (
    input  logic         clk,
    input  logic         rst_n,
    alu_arbiter_if.slave bus,
    output logic [31:0]  alu_dat1,
    output logic [31:0]  alu_dat2,
    output logic [3:0]   alu_control,
    input  logic [31:0]  alu_result,
    output logic         flag_z,
    output logic         flag_n
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t      state;
    logic        prio;
    logic        set_q;
    logic        gnt_any;
    logic        gnt_id;
    logic [3:0]  op_sel;
    logic [31:0] dat1_sel;
    logic [31:0] dat2_sel;
    logic        set_sel;

`ifdef ALU_ARB_OPCHECK_EN
    logic        err_q;

    // Opcodes the ALU does not implement
    function automatic logic op_illegal(input logic [3:0] op);
        return op > 4'd5;
    endfunction
`else
    assign bus.rsp_err = 1'b0;
`endif

    // Grant selection: prio breaks ties, a lone requester always wins
    always_comb begin
        gnt_any = |bus.req_valid;
        gnt_id  = (&bus.req_valid) ? prio : bus.req_valid[1];
        op_sel   = gnt_id ? bus.req_op[7:4]    : bus.req_op[3:0];
        dat1_sel = gnt_id ? bus.req_dat1[63:32] : bus.req_dat1[31:0];
        dat2_sel = gnt_id ? bus.req_dat2[63:32] : bus.req_dat2[31:0];
        set_sel  = gnt_id ? bus.req_set[1]      : bus.req_set[0];
        bus.req_ready = 2'b00;
        if (state == IDLE && gnt_any)
            bus.req_ready = gnt_id ? 2'b10 : 2'b01;
    end

    // Control FSM: accept in IDLE, sample ALU in EXEC, hold response in RESP
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= IDLE;
            prio           <= 1'b0;
            set_q          <= 1'b0;
            alu_dat1       <= '0;
            alu_dat2       <= '0;
            alu_control    <= '0;
            flag_z         <= 1'b0;
            flag_n         <= 1'b0;
            bus.rsp_valid  <= 1'b0;
            bus.rsp_id     <= 1'b0;
            bus.rsp_result <= '0;
`ifdef ALU_ARB_OPCHECK_EN
            err_q          <= 1'b0;
            bus.rsp_err    <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (gnt_any) begin
                        alu_dat1    <= dat1_sel;
                        alu_dat2    <= dat2_sel;
                        alu_control <= op_sel;
                        set_q       <= set_sel;
                        bus.rsp_id  <= gnt_id;
`ifdef ALU_ARB_OPCHECK_EN
                        err_q       <= op_illegal(op_sel);
`endif
                        state       <= EXEC;
                    end
                end
                EXEC: begin
`ifdef ALU_ARB_OPCHECK_EN
                    bus.rsp_err <= err_q;
                    if (err_q) begin
                        bus.rsp_result <= '0;
                    end else begin
                        bus.rsp_result <= alu_result;
                        if (set_q) begin
                            flag_z <= (alu_result == 32'd0);
                            flag_n <= alu_result[31];
                        end
                    end
`else
                    bus.rsp_result <= alu_result;
                    if (set_q) begin
                        flag_z <= (alu_result == 32'd0);
                        flag_n <= alu_result[31];
                    end
`endif
                    bus.rsp_valid <= 1'b1;
                    state         <= RESP;
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        bus.rsp_valid <= 1'b0;
                        prio          <= ~bus.rsp_id;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural ALU attached.
module tb_alu_arbiter;

    logic        clk;
    logic        rst_n;
    logic [31:0] alu_dat1;
    logic [31:0] alu_dat2;
    logic [3:0]  alu_control;
    logic [31:0] alu_result;
    logic        flag_z;
    logic        flag_n;
    int          n_checks;
    int          n_fail;

    alu_arbiter_if bus ();

    alu_arbiter dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .alu_dat1    (alu_dat1),
        .alu_dat2    (alu_dat2),
        .alu_control (alu_control),
        .alu_result  (alu_result),
        .flag_z      (flag_z),
        .flag_n      (flag_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural combinational ALU
    always_comb begin
        alu_result = 32'hFFFF_FFFF;
        case (alu_control)
            4'd0: alu_result = alu_dat1 + alu_dat2;
            4'd1: alu_result = alu_dat1 - alu_dat2;
            4'd2: alu_result = alu_dat1 * alu_dat2;
            4'd3: alu_result = alu_dat1 | alu_dat2;
            4'd4: alu_result = alu_dat1 << alu_dat2[4:0];
            4'd5: alu_result = alu_dat1 >> alu_dat2[4:0];
            default: alu_result = 32'hFFFF_FFFF;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic load(input int i, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic s);
        bus.req_op[i*4 +: 4]    = op;
        bus.req_dat1[i*32 +: 32] = a;
        bus.req_dat2[i*32 +: 32] = b;
        bus.req_set[i]           = s;
        bus.req_valid[i]         = 1'b1;
    endtask

    // Serve one transaction starting in an IDLE cycle with requests presented
    task automatic serve(input string tag, input logic id, input logic [31:0] res,
                         input logic z, input logic n, input logic err, input int hold);
        logic [1:0] oh;
        oh = id ? 2'b10 : 2'b01;
        bus.rsp_ready = (hold == 0);
        #1;
        check({tag, "_grant"}, bus.req_ready, oh);
        tick();
        bus.req_valid[id] = 1'b0;
        #1;
        check({tag, "_exec_vld"}, bus.rsp_valid, 0);
        check({tag, "_exec_rdy"}, bus.req_ready, 0);
        tick();
        #1;
        check({tag, "_rsp_vld"}, bus.rsp_valid, 1);
        check({tag, "_rsp_id"}, bus.rsp_id, id);
        check({tag, "_result"}, bus.rsp_result, res);
        check({tag, "_err"}, bus.rsp_err, err);
        check({tag, "_flag_z"}, flag_z, z);
        check({tag, "_flag_n"}, flag_n, n);
        check({tag, "_rsp_rdy"}, bus.req_ready, 0);
        for (int k = 0; k < hold; k++) begin
            tick();
            check({tag, "_hold_vld"}, bus.rsp_valid, 1);
            check({tag, "_hold_res"}, bus.rsp_result, res);
            check({tag, "_hold_rdy"}, bus.req_ready, 0);
        end
        bus.rsp_ready = 1'b1;
        tick();
        #1;
        check({tag, "_done_vld"}, bus.rsp_valid, 0);
    endtask

    initial begin
        n_checks      = 0;
        n_fail        = 0;
        rst_n         = 1'b0;
        bus.req_valid = '0;
        bus.req_op    = '0;
        bus.req_dat1  = '0;
        bus.req_dat2  = '0;
        bus.req_set   = '0;
        bus.rsp_ready = 1'b0;

        do_reset();
        #1;
        check("rst_rsp_vld", bus.rsp_valid, 0);
        check("rst_req_rdy", bus.req_ready, 0);
        check("rst_rsp_id", bus.rsp_id, 0);
        check("rst_result", bus.rsp_result, 0);
        check("rst_err", bus.rsp_err, 0);
        check("rst_flags", {flag_z, flag_n}, 0);
        check("rst_alu", {alu_control, alu_dat1[27:0]}, 0);

        // Single add with flag update
        load(0, 4'd0, 32'd3, 32'd4, 1'b1);
        serve("add", 1'b0, 32'd7, 1'b0, 1'b0, 1'b0, 0);
        check("hold_dat1", alu_dat1, 32'd3);
        check("hold_dat2", alu_dat2, 32'd4);

        // Both valid from reset: req0 first, req1 leaves zero flag alone
        do_reset();
        load(0, 4'd1, 32'd5, 32'd5, 1'b1);
        load(1, 4'd3, 32'h0000_00F0, 32'h0000_000F, 1'b0);
        serve("sub0", 1'b0, 32'd0, 1'b1, 1'b0, 1'b0, 0);
        serve("or1", 1'b1, 32'h0000_00FF, 1'b1, 1'b0, 1'b0, 0);

        // Continuous contention: grants alternate 0,1,0,1
        load(0, 4'd1, 32'd3, 32'd5, 1'b1);
        load(1, 4'd2, 32'd6, 32'd7, 1'b0);
        serve("rr0", 1'b0, 32'hFFFF_FFFE, 1'b0, 1'b1, 1'b0, 0);
        load(0, 4'd0, 32'hFFFF_FFFF, 32'd1, 1'b1);
        serve("rr1", 1'b1, 32'd42, 1'b0, 1'b1, 1'b0, 0);
        load(1, 4'd5, 32'h8000_0000, 32'd4, 1'b1);
        serve("rr2", 1'b0, 32'd0, 1'b1, 1'b0, 1'b0, 0);
        serve("rr3", 1'b1, 32'h0800_0000, 1'b0, 1'b0, 1'b0, 0);

        // Consumer stalls five cycles while req1 waits
        load(0, 4'd3, 32'h1234_0000, 32'h0000_5678, 1'b0);
        load(1, 4'd0, 32'd10, 32'd20, 1'b0);
        serve("stall", 1'b0, 32'h1234_5678, 1'b0, 1'b0, 1'b0, 5);
        serve("after", 1'b1, 32'd30, 1'b0, 1'b0, 1'b0, 0);

        // Lone requester wins regardless of prio
        load(1, 4'd4, 32'd1, 32'd31, 1'b1);
        serve("lsl1", 1'b1, 32'h8000_0000, 1'b0, 1'b1, 1'b0, 0);
        load(0, 4'd1, 32'd9, 32'd9, 1'b1);
        serve("zero", 1'b0, 32'd0, 1'b1, 1'b0, 1'b0, 0);

        // Unsupported opcode
        load(0, 4'd7, 32'd1, 32'd2, 1'b1);
`ifdef ALU_ARB_OPCHECK_EN
        serve("op7", 1'b0, 32'd0, 1'b1, 1'b0, 1'b1, 0);
`else
        serve("op7", 1'b0, 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b0, 0);
`endif

        // Reset during EXEC of req1 lsl aborts the operation
        load(1, 4'd4, 32'd1, 32'd4, 1'b1);
        #1;
        check("abort_grant", bus.req_ready, 2'b10);
        tick();
        bus.req_valid = '0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        #1;
        check("abort_vld", bus.rsp_valid, 0);
        check("abort_flags", {flag_z, flag_n}, 0);
        check("abort_id", bus.rsp_id, 0);
        check("abort_res", bus.rsp_result, 0);
        check("abort_alu", alu_control, 0);
        check("abort_dat1", alu_dat1, 0);
        for (int k = 0; k < 3; k++) begin
            tick();
            check("abort_quiet", bus.rsp_valid, 0);
        end
        load(0, 4'd0, 32'd1, 32'd1, 1'b0);
        load(1, 4'd0, 32'd2, 32'd2, 1'b0);
        serve("post0", 1'b0, 32'd2, 1'b0, 1'b0, 1'b0, 0);
        serve("post1", 1'b1, 32'd4, 1'b0, 1'b0, 1'b0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
